// File: rtl/tr_pkg.sv
// Shared definitions for the T/R front-end sequencer: state encoding, default
// guard times and TR polarity.
package tr_pkg;

    typedef enum logic [2:0] {
        StIdleRx = 3'd0,
        StLnaOff = 3'd1,
        StSwTx   = 3'd2,
        StTxOn   = 3'd3,
        StPaOff  = 3'd4,
        StSwRx   = 3'd5
    } tr_state_e;

    localparam int unsigned TLnaOffDef   = 4;
    localparam int unsigned TSwSettleDef = 8;
    localparam int unsigned TPaOffDef    = 4;
    localparam int unsigned TTxMaxDef    = 50000;

    localparam logic TR_TX_LEVEL = 1'b0;

    // A zero-length guard still costs one cycle.
    function automatic int unsigned guard_cycles(int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/tr_sequencer_guard_timer.sv
// Loadable guard down-counter: load_i loads n_i-1 (n_i of 0 acts as 1), then
// counts down to zero and holds; done_o is high while the count is zero.
module tr_guard_timer
    import tr_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RST_N = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] RstCnt = CNT_W'(guard_cycles(RST_N) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (n_i == '0) ? '0 : n_i - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RstCnt;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tr_sequencer.sv
// Break-before-make sequencer for the T/R switch, PA and LNA driven by the filtered TR level.
// Optional TX watchdog enabled by defining TR_TIMEOUT_EN.
module tr_sequencer
    import tr_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned T_LNA_OFF   = TLnaOffDef,
    parameter int unsigned T_SW_SETTLE = TSwSettleDef,
    parameter int unsigned T_PA_OFF    = TPaOffDef,
    parameter int unsigned T_TX_MAX    = TTxMaxDef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tr,
    input  logic [1:0]  tr_edge,
    output logic        pa_en,
    output logic        sw_tx,
    output logic        lna_en,
    output logic        busy,
    output logic [2:0]  state_o,
    output logic [15:0] tx_cnt,
    output logic        tx_fault
);

    tr_state_e        state_q, state_d;
    logic             timer_load, timer_done;
    logic [CNT_W-1:0] timer_n;
    logic             tx_req, tx_inc;
    logic             pa_en_d, sw_tx_d, lna_en_d;

    assign tx_req = (tr == TR_TX_LEVEL);

`ifdef TR_TIMEOUT_EN
    logic timeout, fault_q, fault_d;

    // A fresh timeout wins over a same-cycle end-of-transmit edge.
    always_comb begin
        fault_d = fault_q;
        if (timeout) begin
            fault_d = 1'b1;
        end else if (tr_edge == 2'b01) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign tx_fault = fault_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{tr_edge, CNT_W'(T_TX_MAX)};
    assign tx_fault   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tx_inc  = 1'b0;
`ifdef TR_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            StIdleRx: if (tx_req && !tx_fault) state_d = StLnaOff;
            StLnaOff: begin
                if (!tx_req)         state_d = StSwRx;
                else if (timer_done) state_d = StSwTx;
            end
            StSwTx: begin
                if (!tx_req)         state_d = StSwRx;
                else if (timer_done) state_d = StTxOn;
            end
            StTxOn: begin
                if (!tx_req) begin
                    state_d = StPaOff;
                    tx_inc  = 1'b1;
                end
`ifdef TR_TIMEOUT_EN
                else if (timer_done) begin
                    state_d = StPaOff;
                    timeout = 1'b1;
                end
`endif
            end
            StPaOff:  if (timer_done) state_d = StSwRx;
            StSwRx:   if (timer_done) state_d = StIdleRx;
            default:  state_d = StPaOff;
        endcase
    end

    // Reload the guard timer on every state entry with that state's duration.
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            StLnaOff:        timer_n = CNT_W'(T_LNA_OFF);
            StSwTx, StSwRx:  timer_n = CNT_W'(T_SW_SETTLE);
            StPaOff:         timer_n = CNT_W'(T_PA_OFF);
`ifdef TR_TIMEOUT_EN
            StTxOn:          timer_n = CNT_W'(T_TX_MAX);
`endif
            default:         timer_n = CNT_W'(1);
        endcase
    end

    always_comb begin
        pa_en_d  = 1'b0;
        sw_tx_d  = 1'b0;
        lna_en_d = 1'b0;
        case (state_d)
            StIdleRx:        lna_en_d = 1'b1;
            StSwTx, StPaOff: sw_tx_d  = 1'b1;
            StTxOn: begin
                pa_en_d = 1'b1;
                sw_tx_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSwRx;
            pa_en   <= 1'b0;
            sw_tx   <= 1'b0;
            lna_en  <= 1'b0;
            busy    <= 1'b1;
            tx_cnt  <= '0;
        end else begin
            state_q <= state_d;
            pa_en   <= pa_en_d;
            sw_tx   <= sw_tx_d;
            lna_en  <= lna_en_d;
            busy    <= (state_d != StIdleRx);
            if (tx_inc) tx_cnt <= tx_cnt + 16'd1;
        end
    end

    assign state_o = state_q;

    tr_guard_timer #(
        .CNT_W (CNT_W),
        .RST_N (T_SW_SETTLE)
    ) u_guard_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .n_i    (timer_n),
        .done_o (timer_done)
    );

endmodule

// File: tb/tb_tr_sequencer.sv
// Scoreboard bench for tr_sequencer; covers the watchdog when TR_TIMEOUT_EN is defined.
module tb_tr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tr = 1'b1;
    logic [1:0]  tr_edge = 2'b11;
    logic        pa_en, sw_tx, lna_en, busy, tx_fault;
    logic [2:0]  state_o;
    logic [15:0] tx_cnt;

    int n_pass = 0;
    int n_fail = 0;

`ifdef TR_TIMEOUT_EN
    localparam int Hold = 10;
`else
    localparam int Hold = 100;
`endif

    typedef struct {
        string       name;
        int          wt;
        logic [23:0] v;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    logic [23:0] obs;
    assign obs = {pa_en, sw_tx, lna_en, busy, state_o, tx_fault, tx_cnt};

    tr_sequencer #(
        .T_TX_MAX (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tr       (tr),
        .tr_edge  (tr_edge),
        .pa_en    (pa_en),
        .sw_tx    (sw_tx),
        .lna_en   (lna_en),
        .busy     (busy),
        .state_o  (state_o),
        .tx_cnt   (tx_cnt),
        .tx_fault (tx_fault)
    );

    always #5 clk = ~clk;

    // Expected {pa, sw, lna, busy} per state, then state, fault, count.
    function automatic logic [23:0] expv(input int st, input int cnt, input bit fault);
        logic [3:0] o;
        case (st)
            0:       o = 4'b0010;
            1:       o = 4'b0001;
            2:       o = 4'b0101;
            3:       o = 4'b1101;
            4:       o = 4'b0101;
            default: o = 4'b0001;
        endcase
        return {o, 3'(st), fault, 16'(cnt)};
    endfunction

    task automatic push(input string name, input int wt, input int st, input int cnt,
                        input bit fault);
        exp_t x;
        x.name = name;
        x.wt   = wt;
        x.v    = expv(st, cnt, fault);
        sb_q.push_back(x);
    endtask

    // Pushes the expected path IDLE_RX -> LNA_OFF -> SW_TX -> TX_ON.
    task automatic push_to_tx(input int cnt, input bit fault);
        push("lna_off_enter", 1, 1, cnt, fault);
        push("lna_off_end", 3, 1, cnt, fault);
        push("sw_tx_enter", 1, 2, cnt, fault);
        push("sw_tx_end", 7, 2, cnt, fault);
        push("tx_on_enter", 1, 3, cnt, fault);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((pa_en && (!sw_tx || lna_en)) || (lna_en && (sw_tx || pa_en))) begin
                n_fail++;
                $display("FAIL invariant: got pa=%b sw=%b lna=%b want break-before-make",
                         pa_en, sw_tx, lna_en);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tr  = 1'b1;
        repeat (2) @(negedge clk);
        push("reset_hold", 0, 5, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        rst = 1'b0;
        push("reset_release", 0, 5, 0, 0);
        for (int i = 0; i < 7; i++) push("reset_settle", 1, 5, 0, 0);
        push("reset_idle", 1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask

    task automatic test_tx_sequence();
        tr = 1'b0;
        push_to_tx(0, 0);
        push("tx_on_hold", Hold, 3, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        push("pa_off_enter", 1, 4, 1, 0);
        push("pa_off_end", 3, 4, 1, 0);
        push("sw_rx_enter", 1, 5, 1, 0);
        push("sw_rx_end", 7, 5, 1, 0);
        push("rx_idle", 1, 0, 1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask

    task automatic test_abort();
        tr = 1'b0;
        push("ab_lna_off", 1, 1, 1, 0);
        push("ab_sw_tx", 4, 2, 1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        for (int i = 0; i < 8; i++) push("ab_sw_rx", 1, 5, 1, 0);
        push("ab_idle", 1, 0, 1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        // Abort from LNA_OFF as well.
        tr = 1'b0;
        push("ab2_lna_off", 1, 1, 1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        push("ab2_sw_rx", 1, 5, 1, 0);
        push("ab2_sw_rx_end", 7, 5, 1, 0);
        push("ab2_idle", 1, 0, 1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        tr = 1'b0;
        push_to_tx(1, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        push("b2b_pa_off", 1, 4, 2, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b0;
        push("b2b_pa_off_end", 3, 4, 2, 0);
        push("b2b_sw_rx", 1, 5, 2, 0);
        push("b2b_sw_rx_end", 7, 5, 2, 0);
        push("b2b_idle", 1, 0, 2, 0);
        push("b2b_restart", 1, 1, 2, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        push("b2b_abort", 1, 5, 2, 0);
        push("b2b_idle2", 8, 0, 2, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        tr = 1'b0;
        push_to_tx(2, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        #2 rst = 1'b1;
        #1 push("async_reset", 0, 5, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        @(negedge clk);
        tr  = 1'b1;
        rst = 1'b0;
        push("mid_release", 0, 5, 0, 0);
        push("mid_settle", 7, 5, 0, 0);
        push("mid_idle", 1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask

`ifdef TR_TIMEOUT_EN
    task automatic test_timeout();
        tr = 1'b0;
        push_to_tx(0, 0);
        push("wd_tx_last", 19, 3, 0, 0);
        push("wd_pa_off", 1, 4, 0, 1);
        push("wd_sw_rx", 4, 5, 0, 1);
        push("wd_idle", 8, 0, 0, 1);
        push("wd_no_restart", 5, 0, 0, 1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr      = 1'b1;
        tr_edge = 2'b01;
        push("wd_clear", 1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr_edge = 2'b11;
        tr      = 1'b0;
        push("wd_restart", 1, 1, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
        tr = 1'b1;
        push("wd_abort_idle", 9, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            repeat (e.wt) @(negedge clk);
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.v);
            end else n_pass++;
        end
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by time %0t want finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_sequence();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef TR_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
